// File: rtl/exec_muldiv_if.sv
// Execute-stage multiply/divide bus: operation request from the pipeline and
// completion/stall feedback from the unit.
interface exec_muldiv_if #(
  parameter int XLEN = 32
);
  logic            FlushE;
  logic            StartE;
  logic [2:0]      FunctE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic            StallE;

  modport master (
    output FlushE, StartE, FunctE, SrcAE, SrcBE,
    input  Busy, Done, Result, StallE
  );

  modport slave (
    input  FlushE, StartE, FunctE, SrcAE, SrcBE,
    output Busy, Done, Result, StallE
  );
endinterface

// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative radix-2 shift-add multiplier and restoring divider.
// Divider datapath is compiled in only when MULDIV_DIV_EN is defined.
module exec_muldiv #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  exec_muldiv_if.slave      bus,
  output logic [1:0]        dbgState
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   count;
  logic [2:0]      opReg;
  logic            negA, negB;
  logic [XLEN-1:0] hiReg, loReg, bReg, resultReg;

  logic            aSigned, bSigned, aNegIn, bNegIn;
  logic [XLEN-1:0] aMag, bMag;
  logic            accept, immediate;
  logic [XLEN-1:0] immResult;
  logic [XLEN-1:0] stepHi, stepLo, finalResult;

  // Handshake: an op is accepted when StartE=1, FlushE=0 and the unit is not
  // BUSY; StallE holds the pipeline from acceptance until the Done pulse, and
  // Done is a one-cycle pulse with Result valid (Result then holds).

  assign aSigned = ~(bus.FunctE[0] & (bus.FunctE[1] | bus.FunctE[2]));
  assign bSigned = aSigned & (bus.FunctE != 3'b010);
  assign aNegIn  = aSigned & bus.SrcAE[XLEN-1];
  assign bNegIn  = bSigned & bus.SrcBE[XLEN-1];
  assign aMag    = aNegIn ? -bus.SrcAE : bus.SrcAE;
  assign bMag    = bNegIn ? -bus.SrcBE : bus.SrcBE;
  assign accept  = bus.StartE & ~bus.FlushE & (state != BUSY);

`ifdef MULDIV_DIV_EN
  logic divZero, divOverflow;
  assign divZero     = bus.FunctE[2] & (bus.SrcBE == '0);
  assign divOverflow = bus.FunctE[2] & ~bus.FunctE[0] & (bus.SrcBE == '1) &
                       (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}});
  assign immediate   = divZero | divOverflow;
  always_comb begin
    immResult = '0;
    if (divZero)          immResult = bus.FunctE[1] ? bus.SrcAE : '1;
    else if (divOverflow) immResult = bus.FunctE[1] ? '0 : bus.SrcAE;
  end
`else
  // Without a divider every divide/remainder op completes at once with zero.
  assign immediate = bus.FunctE[2];
  assign immResult = '0;
`endif

  always_comb begin
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mulResult;
    mulSum    = loReg[0] ? ({1'b0, hiReg} + {1'b0, bReg}) : {1'b0, hiReg};
    stepHi    = mulSum[XLEN:1];
    stepLo    = {mulSum[0], loReg[XLEN-1:1]};
    product   = {stepHi, stepLo};
    if (negA ^ negB) product = -product;
    mulResult = (opReg[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    finalResult = opReg[2] ? '0 : mulResult;
`ifdef MULDIV_DIV_EN
    begin
      logic [XLEN:0]   shifted;
      logic [XLEN-1:0] quo, rem;
      shifted = {hiReg, loReg[XLEN-1]};
      if (opReg[2]) begin
        if (shifted >= {1'b0, bReg}) begin
          stepHi = shifted[XLEN-1:0] - bReg;
          stepLo = {loReg[XLEN-2:0], 1'b1};
        end else begin
          stepHi = shifted[XLEN-1:0];
          stepLo = {loReg[XLEN-2:0], 1'b0};
        end
        quo = (negA ^ negB) ? -stepLo : stepLo;
        rem = negA ? -stepHi : stepHi;
        finalResult = opReg[1] ? rem : quo;
      end
    end
`endif
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (bus.FlushE)      stateNext = IDLE;
        else if (bus.StartE) stateNext = immediate ? DONE : BUSY;
        else                 stateNext = IDLE;
      end
      BUSY: begin
        if (bus.FlushE)                 stateNext = IDLE;
        else if (count == CW'(1))       stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      opReg     <= '0;
      negA      <= 1'b0;
      negB      <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
      bReg      <= '0;
      resultReg <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        opReg <= bus.FunctE;
        negA  <= aNegIn;
        negB  <= bNegIn;
        hiReg <= '0;
`ifdef MULDIV_DIV_EN
        loReg <= bus.FunctE[2] ? aMag : bMag;
        bReg  <= bus.FunctE[2] ? bMag : aMag;
`else
        loReg <= bMag;
        bReg  <= aMag;
`endif
        count <= immediate ? '0 : CW'(XLEN);
        if (immediate) resultReg <= immResult;
      end else if (state == BUSY) begin
        if (bus.FlushE) begin
          count <= '0;
        end else begin
          hiReg <= stepHi;
          loReg <= stepLo;
          count <= count - CW'(1);
          if (count == CW'(1)) resultReg <= finalResult;
        end
      end
    end
  end

  assign bus.Busy   = (state == BUSY);
  assign bus.Done   = (state == DONE);
  assign bus.Result = resultReg;
  assign bus.StallE = (state == BUSY) | accept;
  assign dbgState   = state;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv (XLEN=32): vector table plus flush,
// back-to-back, ignored-start and mid-operation reset sequences.
module tb_exec_muldiv;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] dbgState;
  int         nChecks;
  int         nErrors;
  logic [31:0] holdRes;

  exec_muldiv_if #(.XLEN(32)) bus ();

  exec_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issue one op in the current cycle (cycle 0) and follow it to Done
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int doneAt;
    int busyCnt;
    bus.StartE = 1'b1;
    bus.FunctE = f;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    #1;
    check({name, ".stall0"}, 64'(bus.StallE), 64'd1);
    tick();
    bus.StartE = 1'b0;
    if (expLat > 1) check({name, ".hold1"}, 64'(bus.Result), 64'(holdRes));
    doneAt  = -1;
    busyCnt = 0;
    for (int c = 1; c <= 100 && doneAt < 0; c++) begin
      if (bus.Busy) busyCnt++;
      if (bus.Done) begin
        doneAt = c;
        check({name, ".result"}, 64'(bus.Result), 64'(expRes));
      end else begin
        tick();
      end
    end
    check({name, ".latency"}, 64'(doneAt), 64'(expLat));
    check({name, ".busyCycles"}, 64'(busyCnt), 64'(expLat - 1));
    tick();
    check({name, ".pulse"}, 64'({bus.Done, dbgState}), 64'({1'b0, ST_IDLE}));
    holdRes = expRes;
  endtask

  task automatic watch_no_done(input string name, input logic [31:0] expRes);
    int sawDone;
    sawDone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.Done) sawDone++;
      tick();
    end
    check({name, ".noDone"}, 64'(sawDone), 64'd0);
    check({name, ".resultKept"}, 64'(bus.Result), 64'(expRes));
  endtask

  initial begin
    int doneAt;
    int busyCnt;
    nChecks    = 0;
    nErrors    = 0;
    holdRes    = '0;
    reset      = 1'b1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.FunctE = '0;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;

    vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{3'b000, 32'h12345678, 32'h10,       32'h23456780, 33});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,  DIV_ON ? 32'hFFFFFFFD : 32'h0, DIV_ON ? 33 : 1});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,  DIV_ON ? 32'hFFFFFFFF : 32'h0, DIV_ON ? 33 : 1});
    vecs.push_back('{3'b101, 32'd5,        32'd0,  DIV_ON ? 32'hFFFFFFFF : 32'h0, 1});
    vecs.push_back('{3'b111, 32'd5,        32'd0,  DIV_ON ? 32'd5        : 32'h0, 1});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, DIV_ON ? 32'h80000000 : 32'h0, 1});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{3'b101, 32'd100,      32'd7,  DIV_ON ? 32'd14       : 32'h0, DIV_ON ? 33 : 1});
    vecs.push_back('{3'b111, 32'd100,      32'd7,  DIV_ON ? 32'd2        : 32'h0, DIV_ON ? 33 : 1});
    vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, DIV_ON ? 32'hFFFFFFFD : 32'h0, DIV_ON ? 33 : 1});
    vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, DIV_ON ? 32'd1        : 32'h0, DIV_ON ? 33 : 1});
    vecs.push_back('{3'b100, 32'd10,       32'd2,  DIV_ON ? 32'd5        : 32'h0, DIV_ON ? 33 : 1});

    repeat (3) tick();
    reset = 1'b0;
    check("reset.state",  64'(dbgState),   64'(ST_IDLE));
    check("reset.busy",   64'(bus.Busy),   64'd0);
    check("reset.done",   64'(bus.Done),   64'd0);
    check("reset.stall",  64'(bus.StallE), 64'd0);
    check("reset.result", 64'(bus.Result), 64'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
             vecs[i].expRes, vecs[i].expLat);

    // flush a MUL in cycle 10
    bus.StartE = 1'b1; bus.FunctE = 3'b000; bus.SrcAE = 32'd9; bus.SrcBE = 32'd9;
    tick();
    bus.StartE = 1'b0;
    repeat (9) tick();
    check("flush.busy10", 64'(bus.Busy), 64'd1);
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    check("flush.idle11", 64'({dbgState, bus.Busy, bus.Done, bus.StallE}), 64'({ST_IDLE, 3'b000}));
    watch_no_done("flush", holdRes);

    // StartE together with FlushE starts nothing
    bus.StartE = 1'b1; bus.FlushE = 1'b1;
    #1;
    check("startFlush.stall", 64'(bus.StallE), 64'd0);
    tick();
    bus.StartE = 1'b0; bus.FlushE = 1'b0;
    check("startFlush.idle", 64'(dbgState), 64'(ST_IDLE));
    watch_no_done("startFlush", holdRes);

    // back-to-back: MUL 3x4, restart with MUL 5x6 in its DONE cycle
    bus.StartE = 1'b1; bus.FunctE = 3'b000; bus.SrcAE = 32'd3; bus.SrcBE = 32'd4;
    tick();
    bus.StartE = 1'b0;
    repeat (32) tick();
    check("b2b.done33", 64'({bus.Done, bus.Result}), 64'({1'b1, 32'd12}));
    bus.StartE = 1'b1; bus.SrcAE = 32'd5; bus.SrcBE = 32'd6;
    #1;
    check("b2b.stall33", 64'(bus.StallE), 64'd1);
    tick();
    bus.StartE = 1'b0;
    check("b2b.busy34", 64'(bus.Busy), 64'd1);
    doneAt  = -1;
    busyCnt = 0;
    for (int c = 34; c <= 120 && doneAt < 0; c++) begin
      if (c == 40) begin
        bus.StartE = 1'b1; bus.SrcAE = 32'd7; bus.SrcBE = 32'd7;
        #1;
        check("b2b.stallBusy", 64'(bus.StallE), 64'd1);
      end
      if (c == 41) bus.StartE = 1'b0;
      if (bus.Busy) busyCnt++;
      if (bus.Done) begin
        doneAt = c;
        check("b2b.result66", 64'(bus.Result), 64'd30);
      end else begin
        tick();
      end
    end
    check("b2b.doneAt", 64'(doneAt), 64'd66);
    check("b2b.busyRun", 64'(busyCnt), 64'd32);
    tick();
    check("b2b.idle67", 64'({bus.Done, dbgState}), 64'({1'b0, ST_IDLE}));
    holdRes = 32'd30;

    // reset in cycle 5 of a long operation
    bus.StartE = 1'b1; bus.FunctE = DIV_ON ? 3'b100 : 3'b000;
    bus.SrcAE  = 32'd100; bus.SrcBE = 32'd7;
    tick();
    bus.StartE = 1'b0;
    repeat (4) tick();
    check("rst.busy5", 64'(bus.Busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst.cycle6", 64'({dbgState, bus.Busy, bus.Done, bus.StallE}), 64'({ST_IDLE, 3'b000}));
    check("rst.result", 64'(bus.Result), 64'd0);
    holdRes = '0;
    watch_no_done("rst", 32'd0);

    run_op("post", 3'b011, 32'h12345678, 32'h10, 32'h1, 33);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_muldiv.md
EXEC_MULDIV -- requirements
Module: exec_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 FlushE  input  1  abort in-flight operation (execute-stage flush).
REQ-005 StartE  input  1  request new operation using FunctE, SrcAE, SrcBE this cycle.
REQ-006 FunctE  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SrcAE, SrcBE  input  XLEN each  dividend/multiplicand and divisor/multiplier.
REQ-008 Busy  output  1  iteration in progress.
REQ-009 Done  output  1  single-cycle pulse; Result valid.
REQ-010 Result  output  XLEN  last completed result, held until next completion.
REQ-011 StallE  output  1  combinational hold request to hazard unit.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE; Busy=1 only in BUSY, Done=1 only in DONE.
REQ-013 StartE in IDLE or DONE with FlushE=0 SHALL latch operands and op; StartE in BUSY SHALL be ignored.
REQ-014 Latency: StartE accepted in cycle 0 -> BUSY in cycles 1..XLEN -> DONE in cycle XLEN+1 -> IDLE in XLEN+2 unless restarted.
REQ-015 StartE accepted in the DONE cycle SHALL enter BUSY next cycle (back-to-back, no IDLE bubble).
REQ-016 Multiply: radix-2 shift-add over XLEN-bit magnitudes, 2*XLEN product, negated when operand signs differ (signed operands only).
REQ-017 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU product[2*XLEN-1:XLEN] with signed×signed / signed×unsigned / unsigned×unsigned.
REQ-018 Divide: restoring, one quotient bit per BUSY cycle on magnitudes; quotient negated if signs differ, remainder takes dividend sign (DIV/REM).
REQ-019 Divisor zero: quotient all-ones, remainder = SrcAE; FSM SHALL go IDLE->DONE directly (Done in cycle 1).
REQ-020 Signed overflow (SrcAE = -2^(XLEN-1), SrcBE = -1, DIV/REM): quotient = SrcAE, remainder 0; Done in cycle 1.
REQ-021 Iteration counter SHALL be ceil(log2(XLEN+1)) bits, loaded with XLEN, decrementing to 0; no wrap.
REQ-022 StallE = Busy | (StartE & ~FlushE & state != BUSY-final); SHALL be 0 in the DONE cycle unless a new start is accepted.
REQ-023 FlushE in any state SHALL force IDLE next cycle, suppress Done, leave Result unchanged; FlushE with StartE SHALL ignore StartE.
REQ-024 Result SHALL update only on the edge entering DONE.

Reset
REQ-025 reset SHALL force IDLE, Busy=0, Done=0, StallE=0 (absent StartE), Result=0, counter=0, operand registers=0.
REQ-026 reset SHALL dominate FlushE and StartE; reset mid-operation SHALL discard it without Done.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: divide datapath and REQ-018..020 compiled in.
REQ-028 MULDIV_DIV_EN undefined: no divider logic; ops 100-111 SHALL complete IDLE->DONE in cycle 1 with Result=0.

Verification (XLEN=32)
REQ-029 MUL 7 × 0xFFFFFFFD -> Busy cycles 1..32, Done cycle 33, Result 0xFFFFFFEB.
REQ-030 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF Done cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 MUL started, FlushE in cycle 10 -> IDLE cycle 11, no Done, Result keeps prior value; StartE+FlushE same cycle -> no operation.
REQ-033 StartE in DONE cycle of MUL 3×4 with new MUL 5×6 -> Done cycle 33 Result 12, Done cycle 66 Result 30, Busy continuous 34..65.
REQ-034 reset asserted cycle 5 of DIV -> cycle 6 IDLE, Result 0, no Done; without MULDIV_DIV_EN DIV 10/2 -> Done cycle 1, Result 0.
